// File: rtl/fpga_cmd_tx_if.sv
// Request and bus signal bundle for the FPGA command transmitter.
// slave is the transmitter's view; master is the requester/bus-observer view.
interface fpga_cmd_tx_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_command;
    logic [7:0] req_data;
    logic       enable;
    logic [6:0] command;
    logic [7:0] data;
    logic       busy;

    modport master (
        output req_valid, req_command, req_data,
        input  req_ready, enable, command, data, busy
    );

    modport slave (
        input  req_valid, req_command, req_data,
        output req_ready, enable, command, data, busy
    );
endinterface

// File: rtl/fpga_cmd_tx.sv
// Command-bus transmitter: FIFO-buffered requests are driven onto the enable/command/data
// bus with fixed setup, strobe and hold phases around each rising edge of enable.
module fpga_cmd_tx #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input logic          clk,
    input logic          rst_n,
    fpga_cmd_tx_if.slave bus
);
    localparam int unsigned EntryW   = 15;
    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned MaxSt    = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES
                                                                      : STROBE_CYCLES;
    localparam int unsigned MaxPhase = (MaxSt > HOLD_CYCLES) ? MaxSt : HOLD_CYCLES;
    localparam int unsigned TmrW     = (MaxPhase > 1) ? $clog2(MaxPhase) : 1;

    localparam logic [TmrW-1:0] SetupLoad  = TmrW'(SETUP_CYCLES - 1);
    localparam logic [TmrW-1:0] StrobeLoad = TmrW'(STROBE_CYCLES - 1);
    localparam logic [TmrW-1:0] HoldLoad   = TmrW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] FullCount  = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    logic [EntryW-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    state_e            state_q;
    logic [TmrW-1:0]   tmr_q;
    logic              enable_q;
    logic [6:0]        command_q;
    logic [7:0]        data_q;

    logic full, empty, push, pop;

    always_comb begin
        full  = (count_q == FullCount);
        empty = (count_q == '0);
        push  = bus.req_valid && !full;
        // A pop is the only way into SETUP, either from IDLE or at the end of HOLD.
        pop   = !empty && ((state_q == StIdle) || ((state_q == StHold) && (tmr_q == '0)));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.req_command, bus.req_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            enable_q  <= 1'b0;
            command_q <= '0;
            data_q    <= '0;
        end else begin
            if (pop) begin
                command_q <= mem[rd_ptr_q][14:8];
                data_q    <= mem[rd_ptr_q][7:0];
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StSetup;
                        tmr_q   <= SetupLoad;
                    end
                end
                StSetup: begin
                    if (tmr_q == '0) begin
                        state_q  <= StStrobe;
                        enable_q <= 1'b1;
                        tmr_q    <= StrobeLoad;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                StStrobe: begin
                    if (tmr_q == '0) begin
                        state_q  <= StHold;
                        enable_q <= 1'b0;
                        tmr_q    <= HoldLoad;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                StHold: begin
                    if (tmr_q == '0) begin
                        if (pop) begin
                            state_q <= StSetup;
                            tmr_q   <= SetupLoad;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = !full;
    assign bus.busy      = (state_q != StIdle) || !empty;
    assign bus.enable    = enable_q;
    assign bus.command   = command_q;
    assign bus.data      = data_q;
endmodule

// File: tb/tb_fpga_cmd_tx.sv
// Self-checking bench for fpga_cmd_tx: a timeline model of the bus transactions, a
// setup/hold checker and a small decoder model driven by rising edges of enable.
module tb_fpga_cmd_tx;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int STB   = 2;
    localparam int H     = 1;
    localparam int P     = S + STB + H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fpga_cmd_tx_if bus ();

    fpga_cmd_tx #(
        .DEPTH        (DEPTH),
        .SETUP_CYCLES (S),
        .STROBE_CYCLES(STB),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each transaction occupies P cycles starting at its pop edge; a pop happens
    // whenever something is queued and the previous transaction's P cycles have elapsed.
    int          mcyc     = 0;
    int          last_pop = -1000;
    logic [14:0] mq[$];
    logic [14:0] macc[$];
    logic [6:0]  m_cmd    = '0;
    logic [7:0]  m_data   = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            mcyc     = 0;
            last_pop = -1000;
            m_cmd    = '0;
            m_data   = '0;
        end else begin
            bit          do_push;
            logic [14:0] e;
            mcyc++;
            do_push = bus.req_valid && (mq.size() < DEPTH);
            if (mq.size() != 0 && (mcyc - last_pop) >= P) begin
                e        = mq.pop_front();
                m_cmd    = e[14:8];
                m_data   = e[7:0];
                last_pop = mcyc;
            end
            if (do_push) begin
                mq.push_back({bus.req_command, bus.req_data});
                macc.push_back({bus.req_command, bus.req_data});
            end
        end
    end

    // Per-cycle comparison plus setup/hold checker, sampled on the falling edge.
    int          viol     = 0;
    int          sidx     = 0;
    int          chg_idx  = 0;
    int          fall_idx = -100;
    logic        prev_en  = 1'b0;
    logic [14:0] prev_bus = '0;

    initial forever begin
        int   age;
        logic exp_en, exp_busy;
        @(negedge clk);
        age      = mcyc - last_pop;
        exp_en   = (age >= S) && (age < S + STB);
        exp_busy = (mq.size() != 0) || (age < P);
        check("enable", bus.enable, exp_en);
        check("command", bus.command, m_cmd);
        check("data", bus.data, m_data);
        check("req_ready", bus.req_ready, mq.size() < DEPTH);
        check("busy", bus.busy, exp_busy);
        sidx++;
        if (!rst_n) begin
            chg_idx  = sidx;
            fall_idx = -100;
        end else begin
            if ({bus.command, bus.data} != prev_bus) begin
                if (prev_en || bus.enable) viol++;
                if (sidx - fall_idx < H) viol++;
                chg_idx = sidx;
            end
            if (bus.enable && !prev_en && (sidx - chg_idx < S)) viol++;
            if (!bus.enable && prev_en) fall_idx = sidx;
        end
        prev_en  = bus.enable;
        prev_bus = {bus.command, bus.data};
    end

    // Strobe log and decoder model.
    logic [14:0] slog[$];
    time         rise_t[$];
    time         fall_t[$];
    logic [17:0] adcs       = '0;
    logic [63:0] rleds      = '0;
    logic [63:0] gleds      = '0;
    logic        red34_seen = 1'b0;

    initial forever begin
        @(posedge bus.enable);
        rise_t.push_back($time);
        slog.push_back({bus.command, bus.data});
        case (bus.command)
            7'h1: adcs = 18'(1) << bus.data[7:1];
            7'h2: begin
                rleds[bus.data[5:0]] = 1'b1;
                if (bus.data == 8'd34) red34_seen = 1'b1;
            end
            7'h3: rleds[bus.data[5:0]] = 1'b0;
            7'h4: gleds[bus.data[5:0]] = 1'b1;
            7'h5: gleds[bus.data[5:0]] = 1'b0;
            default: ;
        endcase
    end

    initial forever begin
        @(negedge bus.enable);
        fall_t.push_back($time);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [6:0] c, input logic [7:0] d);
        bus.req_valid   = v;
        bus.req_command = c;
        bus.req_data    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic clear_logs();
        slog.delete();
        rise_t.delete();
        fall_t.delete();
        macc.delete();
    endtask

    logic [6:0] single_en = 7'b0011000;
    logic [7:0] exp_full[6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h17};

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_command = '0;
        bus.req_data    = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", bus.enable, 1'b0);
        check("rst_command", bus.command, 7'h0);
        check("rst_data", bus.data, 8'h0);
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: push at E0, strobe over E3..E5.
        drive(1'b1, 7'h2, 8'd5);
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            check("single_enable", bus.enable, single_en[i]);
            if (i == 1) begin
                check("single_cmd", bus.command, 7'h2);
                check("single_data", bus.data, 8'd5);
            end
        end
        check("single_busy", bus.busy, 1'b0);

        // Back-to-back.
        clear_logs();
        for (int i = 0; i < 4; i++) drive(1'b1, 7'h4, 8'(i));
        bus.req_valid = 1'b0;
        wait_idle();
        check("b2b_pulses", slog.size(), 4);
        if (slog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("b2b_order", slog[i], {7'h4, 8'(i)});
                if (i > 0) check("b2b_spacing", 32'(rise_t[i] - rise_t[i-1]), 32'd50);
            end
        end

        // Full FIFO with req_valid held.
        clear_logs();
        for (int i = 0; i < 12; i++) drive(1'b1, 7'h5, 8'h10 + 8'(i));
        bus.req_valid = 1'b0;
        check("full_accepted_model", macc.size(), 6);
        wait_idle();
        check("full_pulses", slog.size(), 6);
        if (slog.size() == 6 && macc.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("full_vs_model", slog[i], macc[i]);
                check("full_data", slog[i], {7'h5, exp_full[i]});
            end
        end

        // Mid-strobe reset.
        for (int i = 0; i < 3; i++) drive(1'b1, 7'h6, 8'(i));
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.enable; i++) begin
            @(posedge clk);
            #1;
        end
        check("mr_saw_enable", bus.enable, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mr_enable", bus.enable, 1'b0);
        check("mr_command", bus.command, 7'h0);
        check("mr_data", bus.data, 8'h0);
        check("mr_ready", bus.req_ready, 1'b1);
        check("mr_busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        @(posedge clk);
        #1;
        drive(1'b1, 7'h7, 8'h55);
        bus.req_valid = 1'b0;
        wait_idle();
        check("mr_pulses", slog.size(), 1);
        check("mr_falls", fall_t.size(), 1);
        if (slog.size() == 1 && fall_t.size() == 1) begin
            check("mr_entry", slog[0], {7'h7, 8'h55});
            check("mr_width", 32'(fall_t[0] - rise_t[0]), 32'd20);
        end

        // Decoder model.
        adcs       = '0;
        rleds      = '0;
        red34_seen = 1'b0;
        drive(1'b1, 7'h1, 8'd6);
        drive(1'b1, 7'h2, 8'd34);
        drive(1'b1, 7'h3, 8'd34);
        bus.req_valid = 1'b0;
        wait_idle();
        check("dec_adcs", adcs, 18'h8);
        check("dec_red34_set", red34_seen, 1'b1);
        check("dec_red34_end", rleds[34], 1'b0);
        check("timing_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fpga_cmd_tx.md
# fpga_cmd_tx

Command-bus transmitter on the controller side of the FPGA command link. Buffers requests (7-bit command, 8-bit data) in a small FIFO and drives them onto the parallel `enable`/`command`/`data` bus consumed by the FPGA command decoder. The decoder acts on each rising edge of `enable`. This block guarantees setup, strobe-width and hold timing around that edge. Bus transactions are issued one at a time, back-to-back when the FIFO is non-empty.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SETUP_CYCLES`, 2: cycles `command`/`data` are stable before `enable` rises; ≥1.
- `STROBE_CYCLES`, 2: cycles `enable` stays high; ≥1.
- `HOLD_CYCLES`, 1: cycles `command`/`data` are stable after `enable` falls; ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; equals !full.
- `req_command`  in  7  command code (e.g. 7'h1 ADC select, 7'h2/7'h3 red LED on/off, 7'h4/7'h5 green LED on/off).
- `req_data`  in  8  command argument.
- `enable`  out  1  bus strobe to decoder.
- `command`  out  7  bus command.
- `data`  out  8  bus data.
- `busy`  out  1  FSM not IDLE, or FIFO non-empty.

## Operation
- **Push:**
  - Occurs on `req_valid && req_ready` at a clock edge.
  - The entry `{req_command, req_data}` is written.
  - `req_ready` is purely !full. No push is accepted while full, even if a pop occurs on the same edge.
- **Pop:** occurs only on a transition into SETUP. The popped entry loads `command`/`data` on that same edge.
- **FIFO:**
  - Occupancy count is $clog2(DEPTH)+1 bits wide.
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
- **FSM states:** IDLE, SETUP, STROBE, HOLD. A single down-counter, sized for the largest parameter, times each phase.
  - IDLE: if FIFO non-empty → pop, go to SETUP, counter = SETUP_CYCLES-1.
  - SETUP: when counter = 0 → STROBE, `enable` ← 1, counter = STROBE_CYCLES-1.
  - STROBE: when counter = 0 → HOLD, `enable` ← 0, counter = HOLD_CYCLES-1.
  - HOLD: when counter = 0 → if FIFO non-empty, pop and go to SETUP (back-to-back); else go to IDLE.
- **Bus values:**
  - `command`/`data` change only on a pop edge.
  - They retain their last values in IDLE.
  - `enable` is a registered output, high only in STROBE.
- **Command handling:**
  - Every code, including unknown or zero, is forwarded unmodified.
  - No filtering or merging is performed.
- **Reset:**
  - Asserting `rst_n` low mid-transaction immediately forces `enable`=0, `command`=0, `data`=0, FIFO empty, state IDLE.
  - No partial strobe completes.
  - During reset, `req_ready`=1 and `busy`=0.

## Timing
- Push at edge E0 → entry visible to FSM after E0; pop at E1 (the next edge) if IDLE.
- `enable` rises at E1+SETUP_CYCLES and falls at E1+SETUP_CYCLES+STROBE_CYCLES.
- The next pop occurs no earlier than E1+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES.
- Transaction period P = SETUP+STROBE+HOLD cycles. Default P = 5 cycles.
- Sustained throughput is one transaction per P cycles.
- Push-to-`enable`-rise latency is 1+SETUP_CYCLES cycles from empty/IDLE. Default is 3.
- `command`/`data` never change while `enable`=1, nor within SETUP/HOLD windows.
- Asynchronous reset assertion takes effect without a clock. Deassertion is synchronized externally; the first FSM action occurs on the first edge after release.

## Test plan
- **Reset values:** hold `rst_n`=0 → `enable`=0, `command`=7'h0, `data`=8'h0, `req_ready`=1, `busy`=0.
- **Single request:** push {7'h2, 8'd5} from IDLE at E0.
  - Bus values: `command`=7'h2 and `data`=8'd5 from E1.
  - Strobe: `enable` high exactly over E3–E5.
  - Idle return: `busy`=0 after E6.
- **Back-to-back:** push 4 entries {7'h4, 8'd0..3} on consecutive edges.
  - Flow control: `req_ready` drops only when 4 entries are resident.
  - Strobes: exactly 4 `enable` pulses, 5 cycles apart.
  - Ordering: data order is 0, 1, 2, 3.
- **Full FIFO:** hold `req_valid` while full → no push accepted.
  - After the next pop, `req_ready`=1 and one push is accepted.
  - No entry is lost or duplicated.
- **Mid-strobe reset:** assert `rst_n`=0 while `enable`=1 → `enable`=0 immediately.
  - The queued remainder is discarded.
  - After release, a fresh request produces a normal 5-cycle transaction.
- **Timing checker with decoder model:**
  - Bench model: a decoder applies {7'h1, 8'd6}, {7'h2, 8'd34}, {7'h3, 8'd34} on posedge `enable`.
  - Required decoder end state: adcs=18'h8, rleds bit 34 = 0.
  - Required checker result: no setup/hold violation flagged.
